z80_bus_responder: RTL
======================

Name: z80_bus_responder

Overview:
Bus-side responder for the Z80 core's external pins. It decodes memory, I/O and interrupt-acknowledge cycles from the CPU's control strobes and forwards each decoded cycle to a simple request/acknowledge backend (RAM, ROM, peripherals). It stretches the bus cycle with WAIT_n until the backend answers, drives read data or the interrupt vector onto the data bus, and times out hung accesses.

Parameters:
TIMEOUT, 255, maximum cycles to wait for bk_ack before aborting; width 8..16 bits.
INT_VECTOR, 8'hFF, byte returned during interrupt acknowledge (RST 38h by default).
IO_ADDR_BITS, 8, low address bits forwarded for I/O cycles; upper bits forced to 0.

Ports:
CLK  input  1  system clock, same clock as the CPU.
RESET_n  input  1  asynchronous active-low reset.
M1_n  input  1  CPU opcode-fetch / INTA qualifier.
MREQ_n  input  1  memory request.
IORQ_n  input  1  I/O request.
RD_n  input  1  read strobe.
WR_n  input  1  write strobe.
RFSH_n  input  1  refresh qualifier.
A  input  16  CPU address bus.
D_in  input  8  data from CPU (write cycles).
D_out  output  8  data to CPU.
D_oe  output  1  drive enable for the data bus toward the CPU.
WAIT_n  output  1  wait request to CPU.
bk_req  output  1  backend request, held until bk_ack.
bk_we  output  1  1 = write.
bk_io  output  1  1 = I/O space, 0 = memory space.
bk_addr  output  16  backend address.
bk_wdata  output  8  backend write data.
bk_ack  input  1  backend completion, single-cycle pulse.
bk_rdata  input  8  read data, valid when bk_ack = 1.
timeout_err  output  1  one-cycle pulse on abort.

Behaviour:
- Reset (async on RESET_n low; also mid-cycle): state IDLE, D_out = 0, D_oe = 0, WAIT_n = 1, bk_req = 0, bk_we = 0, bk_io = 0, bk_addr = 0, bk_wdata = 0, timeout_err = 0, timeout counter = 0.
- All strobes are sampled on CLK rising edge. Decode priority, evaluated in IDLE only:
  - INTA: M1_n = 0 & IORQ_n = 0.
  - Refresh: MREQ_n = 0 & RFSH_n = 0. Ignored; no bk_req and WAIT_n stays 1.
  - MEM_RD: MREQ_n = 0 & RD_n = 0.
  - MEM_WR: MREQ_n = 0 & WR_n = 0.
  - IO_RD: IORQ_n = 0 & RD_n = 0.
  - IO_WR: IORQ_n = 0 & WR_n = 0.
  - MREQ_n and IORQ_n both low without M1_n low: illegal, treated as idle.
- States: IDLE, ACCESS, DONE.
- IDLE -> ACCESS on a decoded MEM/IO cycle. On that edge:
  - bk_req = 1 and WAIT_n = 0.
  - Latch bk_addr = A for memory cycles, or {0, A[IO_ADDR_BITS-1:0]} for I/O cycles.
  - bk_we = write; bk_io = I/O; bk_wdata = D_in for writes.
- IDLE -> DONE directly on INTA: D_out = INT_VECTOR, D_oe = 1, WAIT_n = 1, no bk_req.
- ACCESS:
  - Counter increments every cycle; bk_req and all bk_* fields stay stable.
  - On bk_ack: bk_req = 0, WAIT_n = 1. For reads, D_out = bk_rdata and D_oe = 1. Go to DONE.
  - If bk_ack is absent when the counter reaches TIMEOUT: bk_req = 0, WAIT_n = 1, timeout_err pulses once. Reads return D_out = 8'hFF with D_oe = 1. Go to DONE.
  - bk_ack arriving in the same cycle the counter reaches TIMEOUT counts as success; no error.
- DONE:
  - Hold D_out and D_oe until the cycle's strobes release (MREQ_n, IORQ_n, RD_n, WR_n all 1).
  - Then D_oe = 0 and return to IDLE; the counter is cleared.
  - A new cycle is decoded only from IDLE, so the earliest re-decode is the cycle after release.
- Strobes released while in ACCESS (CPU aborted, e.g. bus reset): bk_req stays high until bk_ack or timeout, because the backend handshake must complete. No data is driven; go to DONE, which exits at once.
- Latency: a backend acking in the same cycle it first sees bk_req gives one WAIT cycle (WAIT_n low for exactly one CLK).
- bk_ack seen in IDLE or DONE is ignored.
- D_oe is never 1 during write or refresh cycles.

Test Plan:
- Memory read: MREQ_n = RD_n = 0, A = 16'h1234; backend acks 3 cycles later with 8'hA5 -> bk_addr = 1234, bk_we = 0, bk_io = 0; WAIT_n low 3 cycles; D_out = A5 with D_oe = 1 until strobes rise; then D_oe = 0.
- I/O write: IORQ_n = WR_n = 0, A = 16'hBE7F, D_in = 8'h3C -> bk_io = 1, bk_we = 1, bk_addr = 16'h007F, bk_wdata = 3C; D_oe stays 0 throughout.
- Interrupt acknowledge: M1_n = IORQ_n = 0 with INT_VECTOR = 8'hFF -> D_out = FF, D_oe = 1, WAIT_n stays 1, bk_req never asserted. Refresh cycle (MREQ_n = RFSH_n = 0) -> no bk_req, WAIT_n = 1.
- Timeout with TIMEOUT = 4 and no bk_ack on a memory read -> WAIT_n low 4 cycles; timeout_err high exactly 1 cycle; D_out = FF. Repeat with bk_ack on the 4th cycle -> no timeout_err.
- Back-to-back cycles: read, strobes high for 1 cycle, then write -> second bk_req issued with the write's address and data; no stale D_oe during the write.
- RESET_n pulsed low mid-ACCESS -> all outputs return to reset values asynchronously (WAIT_n = 1, bk_req = 0, D_oe = 0); the next decoded cycle after reset proceeds normally.

Source files
------------

// File: rtl/z80_bus_responder.sv
// Z80 external-bus responder: decodes memory, I/O and INTA cycles, forwards them to a
// req/ack backend, stretches the CPU with WAIT_n and aborts hung accesses on timeout.
//
// state  | meaning
// IDLE   | no cycle in progress; strobes decoded here only
// ACCESS | backend request outstanding, CPU held in wait
// DONE   | access finished; read data held until the CPU releases its strobes
module z80_bus_responder #(
    parameter int         TIMEOUT      = 255,
    parameter logic [7:0] INT_VECTOR   = 8'hFF,
    parameter int         IO_ADDR_BITS = 8
) (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic        M1_n,
    input  logic        MREQ_n,
    input  logic        IORQ_n,
    input  logic        RD_n,
    input  logic        WR_n,
    input  logic        RFSH_n,
    input  logic [15:0] A,
    input  logic [7:0]  D_in,
    output logic [7:0]  D_out,
    output logic        D_oe,
    output logic        WAIT_n,
    output logic        bk_req,
    output logic        bk_we,
    output logic        bk_io,
    output logic [15:0] bk_addr,
    output logic [7:0]  bk_wdata,
    input  logic        bk_ack,
    input  logic [7:0]  bk_rdata,
    output logic        timeout_err
);

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);
    localparam logic [15:0] IO_MASK     = 16'((32'd1 << IO_ADDR_BITS) - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  d_out_q, d_out_d;
    logic        d_oe_q, d_oe_d;
    logic        wait_n_q, wait_n_d;
    logic        bk_req_q, bk_req_d;
    logic        bk_we_q, bk_we_d;
    logic        bk_io_q, bk_io_d;
    logic [15:0] bk_addr_q, bk_addr_d;
    logic [7:0]  bk_wdata_q, bk_wdata_d;
    logic        timeout_err_q, timeout_err_d;
    logic        aborted_q, aborted_d;

    logic released;
    logic is_inta;
    logic is_illegal;
    logic is_rfsh;
    logic is_mem;
    logic is_io;
    logic give_data;

    assign released   = MREQ_n & IORQ_n & RD_n & WR_n;
    assign is_inta    = ~M1_n & ~IORQ_n;
    assign is_illegal = ~MREQ_n & ~IORQ_n;
    assign is_rfsh    = ~MREQ_n & ~RFSH_n;
    assign is_mem     = ~MREQ_n & (~RD_n | ~WR_n);
    assign is_io      = ~IORQ_n & (~RD_n | ~WR_n);
    // Data goes back only for reads the CPU is still waiting on.
    assign give_data  = ~bk_we_q & ~aborted_q & ~released;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        d_out_d       = d_out_q;
        d_oe_d        = d_oe_q;
        wait_n_d      = wait_n_q;
        bk_req_d      = bk_req_q;
        bk_we_d       = bk_we_q;
        bk_io_d       = bk_io_q;
        bk_addr_d     = bk_addr_q;
        bk_wdata_d    = bk_wdata_q;
        timeout_err_d = 1'b0;
        aborted_d     = aborted_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d     = '0;
                aborted_d = 1'b0;
                if (is_inta) begin
                    state_d  = ST_DONE;
                    d_out_d  = INT_VECTOR;
                    d_oe_d   = 1'b1;
                    wait_n_d = 1'b1;
                end else if (is_illegal || is_rfsh) begin
                    state_d = ST_IDLE;
                end else if (is_mem || is_io) begin
                    state_d   = ST_ACCESS;
                    bk_req_d  = 1'b1;
                    wait_n_d  = 1'b0;
                    d_oe_d    = 1'b0;
                    bk_io_d   = ~is_mem;
                    bk_we_d   = RD_n;
                    bk_addr_d = is_mem ? A : (A & IO_MASK);
                    if (RD_n) begin
                        bk_wdata_d = D_in;
                    end
                end
            end
            ST_ACCESS: begin
                cnt_d = cnt_q + 16'd1;
                if (released) begin
                    aborted_d = 1'b1;
                end
                // An ack on the terminal cycle still wins over the timeout.
                if (bk_ack) begin
                    state_d  = ST_DONE;
                    bk_req_d = 1'b0;
                    wait_n_d = 1'b1;
                    if (give_data) begin
                        d_out_d = bk_rdata;
                        d_oe_d  = 1'b1;
                    end
                end else if (cnt_q + 16'd1 == TIMEOUT_CNT) begin
                    state_d       = ST_DONE;
                    bk_req_d      = 1'b0;
                    wait_n_d      = 1'b1;
                    timeout_err_d = 1'b1;
                    if (give_data) begin
                        d_out_d = 8'hFF;
                        d_oe_d  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (released) begin
                    state_d = ST_IDLE;
                    d_oe_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            d_out_q       <= '0;
            d_oe_q        <= 1'b0;
            wait_n_q      <= 1'b1;
            bk_req_q      <= 1'b0;
            bk_we_q       <= 1'b0;
            bk_io_q       <= 1'b0;
            bk_addr_q     <= '0;
            bk_wdata_q    <= '0;
            timeout_err_q <= 1'b0;
            aborted_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            d_out_q       <= d_out_d;
            d_oe_q        <= d_oe_d;
            wait_n_q      <= wait_n_d;
            bk_req_q      <= bk_req_d;
            bk_we_q       <= bk_we_d;
            bk_io_q       <= bk_io_d;
            bk_addr_q     <= bk_addr_d;
            bk_wdata_q    <= bk_wdata_d;
            timeout_err_q <= timeout_err_d;
            aborted_q     <= aborted_d;
        end
    end

    assign D_out       = d_out_q;
    assign D_oe        = d_oe_q;
    assign WAIT_n      = wait_n_q;
    assign bk_req      = bk_req_q;
    assign bk_we       = bk_we_q;
    assign bk_io       = bk_io_q;
    assign bk_addr     = bk_addr_q;
    assign bk_wdata    = bk_wdata_q;
    assign timeout_err = timeout_err_q;

endmodule
